// File: rtl/icon_gen_pkg.sv
// Shared constants, types and sprite artwork for the robot icon generator.
// Sprite art is a constant table so the ROM needs no external load step.
package icon_gen_pkg;

  localparam int unsigned SPRITE_SIZE = 16;
  localparam int unsigned SCALE       = 4;
  localparam int unsigned SCALE_SHIFT = 2;
  localparam logic [9:0]  XFER_ROW    = 10'd480;

  localparam logic [11:0] PAL_CLEAR  = 12'h000;
  localparam logic [11:0] PAL_RED    = 12'hF00;
  localparam logic [11:0] PAL_YELLOW = 12'hFF0;
  localparam logic [11:0] PAL_WHITE  = 12'hFFF;

  typedef enum logic [2:0] {
    ORIENT_N  = 3'd0,
    ORIENT_NE = 3'd1,
    ORIENT_E  = 3'd2,
    ORIENT_SE = 3'd3,
    ORIENT_S  = 3'd4,
    ORIENT_SW = 3'd5,
    ORIENT_W  = 3'd6,
    ORIENT_NW = 3'd7
  } orient_e;

  typedef struct packed {
    logic [7:0] loc_x;
    logic [7:0] loc_y;
    orient_e    dir;
    logic       blink;
  } robot_regs_t;

  function automatic logic [11:0] palette(input logic [1:0] idx);
    case (idx)
      2'd1:    palette = PAL_RED;
      2'd2:    palette = PAL_YELLOW;
      2'd3:    palette = PAL_WHITE;
      default: palette = PAL_CLEAR;
    endcase
  endfunction

  // Sprite 0: upward arrow; sprite 1: arrow toward upper right.
  // White corner markers break mirror symmetry so rotations are distinguishable.
  function automatic logic [1:0] sprite_word(input logic sprite, input logic [3:0] sr,
                                             input logic [3:0] sc);
    sprite_word = 2'd0;
    if (!sprite) begin
      if (sr == 4'd15 && sc == 4'd0)
        sprite_word = 2'd3;
      else if (sr <= 4'd7 && {1'b0, sc} >= 5'd7 - {1'b0, sr} && {1'b0, sc} <= 5'd8 + {1'b0, sr})
        sprite_word = 2'd2;
      else if ((sc == 4'd7 || sc == 4'd8) && sr >= 4'd2)
        sprite_word = 2'd1;
    end else begin
      if (sr == 4'd15 && sc == 4'd15)
        sprite_word = 2'd3;
      else if (sr <= 4'd5 && sc >= 4'd10)
        sprite_word = 2'd2;
      else if ({1'b0, sr} + {1'b0, sc} == 5'd15)
        sprite_word = 2'd1;
    end
  endfunction

endpackage

// File: rtl/icon_rom.sv
// Two 16x16 sprites of 2-bit palette indices, address {sprite, sr, sc},
// one-cycle registered read.
module icon_rom
  import icon_gen_pkg::*;
(
  input  logic       clk_i,
  input  logic [8:0] addr_i,
  output logic [1:0] data_o
);

  logic [1:0] rom [512];
  logic [1:0] data_q;

  for (genvar a = 0; a < 512; a++) begin : g_word
    localparam logic [8:0] A = 9'(a);
    assign rom[a] = sprite_word(A[8], A[7:4], A[3:0]);
  end

  always_ff @(posedge clk_i) begin
    data_q <= rom[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/icon_gen.sv
// Robot icon overlay: double-buffered robot registers, 3-stage pixel pipeline
// (hit test, sprite ROM read, palette lookup) with blink gating.
module icon_gen
  import icon_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pixel_row,
  input  logic [9:0]  pixel_column,
  input  logic        video_on,
  input  logic [7:0]  LocX,
  input  logic [7:0]  LocY,
  input  logic [2:0]  orient,
  input  logic        blink_en,
  input  logic        upd_sysregs,
  output logic [11:0] icon,
  output logic        video_on_out
);

  localparam logic signed [10:0] HALF_S = 11'(SPRITE_SIZE / 2);

  robot_regs_t shadow_q, active_q;
  logic [4:0]  frame_q;
  logic        xfer;

  assign xfer = (pixel_row == XFER_ROW) && (pixel_column == '0);

  // Active copy only moves at the transfer point, so a frame never tears.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
      frame_q  <= '0;
    end else begin
      if (upd_sysregs)
        shadow_q <= '{loc_x: LocX, loc_y: LocY, dir: orient_e'(orient), blink: blink_en};
      if (xfer) begin
        active_q <= shadow_q;
        frame_q  <= frame_q + 5'd1;
      end
    end
  end

  logic signed [10:0] org_x, org_y, rel_c, rel_r;
  logic [2:0]         dir_bits;
  logic               hit_d, blank_d;

  assign dir_bits = active_q.dir;
  assign org_x    = $signed(11'(active_q.loc_x) << SCALE_SHIFT) - HALF_S;
  assign org_y    = $signed(11'(active_q.loc_y) << SCALE_SHIFT) - HALF_S;
  assign rel_c    = $signed({1'b0, pixel_column}) - org_x;
  assign rel_r    = $signed({1'b0, pixel_row}) - org_y;
  assign hit_d    = (rel_c[10:4] == '0) && (rel_r[10:4] == '0);
  assign blank_d  = active_q.blink & frame_q[4];

  logic [3:0] r1_q, c1_q;
  logic [1:0] rot1_q;
  logic       spr1_q, hit1_q, vid1_q, blank1_q;
  logic       hit2_q, vid2_q, blank2_q;
  logic [11:0] icon_q;
  logic        vid3_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r1_q     <= '0;
      c1_q     <= '0;
      rot1_q   <= '0;
      spr1_q   <= 1'b0;
      hit1_q   <= 1'b0;
      vid1_q   <= 1'b0;
      blank1_q <= 1'b0;
    end else begin
      r1_q     <= rel_r[3:0];
      c1_q     <= rel_c[3:0];
      rot1_q   <= dir_bits[2:1];
      spr1_q   <= dir_bits[0];
      hit1_q   <= hit_d;
      vid1_q   <= video_on;
      blank1_q <= blank_d;
    end
  end

  logic [3:0] sr, sc;
  logic [1:0] rom_data;

  always_comb begin
    sr = r1_q;
    sc = c1_q;
    case (rot1_q)
      2'd1:    begin sr = ~c1_q; sc = r1_q;  end
      2'd2:    begin sr = ~r1_q; sc = ~c1_q; end
      2'd3:    begin sr = c1_q;  sc = ~r1_q; end
      default: begin sr = r1_q;  sc = c1_q;  end
    endcase
  end

  icon_rom u_rom (
    .clk_i  (clk),
    .addr_i ({spr1_q, sr, sc}),
    .data_o (rom_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit2_q   <= 1'b0;
      vid2_q   <= 1'b0;
      blank2_q <= 1'b0;
      icon_q   <= PAL_CLEAR;
      vid3_q   <= 1'b0;
    end else begin
      hit2_q   <= hit1_q;
      vid2_q   <= vid1_q;
      blank2_q <= blank1_q;
      icon_q   <= (hit2_q && vid2_q && !blank2_q) ? palette(rom_data) : PAL_CLEAR;
      vid3_q   <= vid2_q;
    end
  end

  assign icon         = icon_q;
  assign video_on_out = vid3_q;

endmodule
